// File: rtl/inst_issue_buffer_pkg.sv
// Shared frontend types: instruction word, word-aligned PC and the fetch entry
// that the issue buffer queues between fetch and decode.
package inst_issue_buffer_pkg;

    localparam int PC_WIDTH_DEF = 30;

    typedef logic [31:0]             inst_word_t;
    typedef logic [PC_WIDTH_DEF-1:0] pc_t;

    typedef struct packed {
        inst_word_t inst;
        pc_t        pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Small circular buffer of fetch entries with synchronous clear.
// A push into a full buffer is dropped; the caller flags that as an overflow.
module inst_fifo
    import inst_issue_buffer_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  entry_t                     wdata,
    output entry_t                     rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_issue_buffer.sv
// Issue stage between fetch and decode: FIFO-backed issue register with a
// same-cycle bypass, multicycle hold, stall/flush handling and fetch back-pressure.
module inst_issue_buffer
    import inst_issue_buffer_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_inst,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    output logic                fetch_stall,
    output logic                issue_valid,
    output logic [31:0]         issue_inst,
    output logic [PC_WIDTH-1:0] issue_pc,
    input  logic                hold,
    input  logic                stall,
    input  logic                flush,
    output logic                hold_stream,
    output logic                overflow
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        inst_word_t          inst;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t             head;
    entry_t             fetch_entry;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;
    logic               advance;
    logic               pop;
    logic               bypass;
    logic               push;
    logic               flush_q;

    assign fetch_entry = '{inst: fetch_inst, pc: fetch_pc};

    // FIFO contents always drain before a bypass, so bypass needs an empty FIFO.
    assign advance = !issue_valid || (!hold && !stall);
    assign pop     = !flush && advance && !empty;
    assign bypass  = !flush && advance && empty && fetch_valid;
    assign push    = !flush && fetch_valid && !bypass;

    inst_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (push),
        .pop    (pop),
        .clear  (flush),
        .wdata  (fetch_entry),
        .rdata  (head),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    // One spare slot catches the word fetch sends before it sees the stall.
    assign fetch_stall = !(flush || flush_q) && (count >= CNT_W'(DEPTH-1));
    assign hold_stream = stall || !issue_valid;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            issue_valid <= 1'b0;
            issue_inst  <= '0;
            issue_pc    <= '0;
            flush_q     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            flush_q <= flush;
            if (push && full) overflow <= 1'b1;
            if (flush) begin
                issue_valid <= 1'b0;
            end else if (pop) begin
                issue_valid <= 1'b1;
                issue_inst  <= head.inst;
                issue_pc    <= head.pc;
            end else if (bypass) begin
                issue_valid <= 1'b1;
                issue_inst  <= fetch_inst;
                issue_pc    <= fetch_pc;
            end else if (advance) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Directed bench for inst_issue_buffer (DEPTH=2): reset, streaming bypass,
// multicycle hold, stall/hold overlap, flush and overflow.
module tb_inst_issue_buffer;

    localparam int DEPTH    = 2;
    localparam int PC_WIDTH = 30;

    logic                clk = 1'b0;
    logic                resetb;
    logic                fetch_valid;
    logic [31:0]         fetch_inst;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                fetch_stall;
    logic                issue_valid;
    logic [31:0]         issue_inst;
    logic [PC_WIDTH-1:0] issue_pc;
    logic                hold;
    logic                stall;
    logic                flush;
    logic                hold_stream;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    inst_issue_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc),
        .fetch_stall (fetch_stall),
        .issue_valid (issue_valid),
        .issue_inst  (issue_inst),
        .issue_pc    (issue_pc),
        .hold        (hold),
        .stall       (stall),
        .flush       (flush),
        .hold_stream (hold_stream),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] inst, input logic [PC_WIDTH-1:0] pc);
        fetch_valid = v;
        fetch_inst  = inst;
        fetch_pc    = pc;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        #3;
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        hold = 0; stall = 0; flush = 0;
        fetch(0, 32'h0, '0);
        do_reset();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", issue_valid); end
        checks++; if (issue_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", issue_inst); end
        checks++; if (issue_pc !== '0) begin errors++; $display("FAIL rst_pc got %h exp 0", issue_pc); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        checks++; if (fetch_stall !== 1'b0 || hold_stream !== 1'b1) begin errors++; $display("FAIL rst_outs got stall=%b hs=%b exp 0/1", fetch_stall, hold_stream); end
        // Queue two entries behind a held instruction, then reset mid-cycle.
        fetch(1, 32'h1111_0000, 30'h100); tick();
        hold = 1;
        fetch(1, 32'h1111_0001, 30'h101); tick();
        fetch(1, 32'h1111_0002, 30'h102); tick();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL rst_queued_stall got %b exp 1", fetch_stall); end
        fetch(0, 32'h0, '0);
        #2;
        resetb = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b0 || hold_stream !== 1'b1) begin
            errors++; $display("FAIL rst_async got v=%b fs=%b hs=%b exp 0/0/1", issue_valid, fetch_stall, hold_stream);
        end
        #1;
        resetb = 1'b1;
        hold = 0;
        tick();
        fetch(1, 32'h2222_0000, 30'h200); tick();
        fetch(0, 32'h0, '0);
        checks++; if (issue_valid !== 1'b1 || issue_inst !== 32'h2222_0000 || issue_pc !== 30'h200) begin
            errors++; $display("FAIL rst_first_issue got v=%b inst=%h pc=%h exp 1/22220000/200", issue_valid, issue_inst, issue_pc);
        end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            fetch(1, 32'hA000_0000 + i, 30'h300 + i);
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_inst !== 32'hA000_0000 + i || issue_pc !== 30'h300 + i) begin
                errors++; $display("FAIL stream_%0d got v=%b inst=%h pc=%h", i, issue_valid, issue_inst, issue_pc);
            end
            checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL stream_stall_%0d got %b exp 0", i, fetch_stall); end
        end
        fetch(0, 32'h0, '0);
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", issue_valid); end
    endtask

    task automatic test_multicycle_hold();
        logic [31:0] exp_stall [5];
        exp_stall = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        fetch(1, 32'h4D00_0000, 30'h400); tick();
        checks++; if (issue_inst !== 32'h4D00_0000 || fetch_stall !== 1'b0) begin errors++; $display("FAIL mc_load got inst=%h fs=%b", issue_inst, fetch_stall); end
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) fetch(1, 32'hB000_0000 + i, 30'h410 + i);
            else       fetch(0, 32'h0, '0);
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_inst !== 32'h4D00_0000) begin errors++; $display("FAIL mc_hold_%0d got inst=%h exp 4d000000", i, issue_inst); end
            checks++; if (fetch_stall !== exp_stall[i][0]) begin errors++; $display("FAIL mc_stall_%0d got %b exp 1", i, fetch_stall); end
        end
        hold = 0;
        tick();
        checks++; if (issue_inst !== 32'hB000_0000 || issue_pc !== 30'h410 || fetch_stall !== 1'b1) begin
            errors++; $display("FAIL mc_b0 got inst=%h pc=%h fs=%b exp b0000000/410/1", issue_inst, issue_pc, fetch_stall);
        end
        tick();
        checks++; if (issue_inst !== 32'hB000_0001 || fetch_stall !== 1'b0) begin
            errors++; $display("FAIL mc_b1 got inst=%h fs=%b exp b0000001/0", issue_inst, fetch_stall);
        end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL mc_drain got %b exp 0", issue_valid); end
    endtask

    task automatic test_stall_hold();
        fetch(1, 32'h5500_0000, 30'h500); tick();
        fetch(0, 32'h0, '0);
        stall = 1; hold = 1;
        #1;
        checks++; if (hold_stream !== 1'b1) begin errors++; $display("FAIL sh_both_hs got %b exp 1", hold_stream); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_inst !== 32'h5500_0000) begin errors++; $display("FAIL sh_both_issue got inst=%h", issue_inst); end
        stall = 0;
        #1;
        checks++; if (hold_stream !== 1'b0) begin errors++; $display("FAIL sh_hold_hs got %b exp 0", hold_stream); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_inst !== 32'h5500_0000 || hold_stream !== 1'b0) begin
            errors++; $display("FAIL sh_hold_issue got v=%b inst=%h hs=%b", issue_valid, issue_inst, hold_stream);
        end
        hold = 0;
        tick();
        checks++; if (issue_valid !== 1'b0 || hold_stream !== 1'b1) begin errors++; $display("FAIL sh_release got v=%b hs=%b exp 0/1", issue_valid, hold_stream); end
    endtask

    task automatic test_flush();
        fetch(1, 32'hF000_0000, 30'h600); tick();
        hold = 1;
        fetch(1, 32'hC000_0000, 30'h610); tick();
        fetch(1, 32'hC000_0001, 30'h611); tick();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL fl_pre_stall got %b exp 1", fetch_stall); end
        flush = 1;
        fetch(1, 32'hD000_0000, 30'h620);
        #1;
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL fl_cycle_stall got %b exp 0", fetch_stall); end
        tick();
        checks++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL fl_after got v=%b fs=%b exp 0/0", issue_valid, fetch_stall); end
        flush = 0; hold = 0;
        fetch(0, 32'h0, '0);
        tick();
        checks++; if (issue_valid !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL fl_empty got v=%b fs=%b exp 0/0", issue_valid, fetch_stall); end
    endtask

    task automatic test_overflow();
        fetch(1, 32'h0F00_0000, 30'h700); tick();
        hold = 1;
        fetch(1, 32'hE000_0000, 30'h710); tick();
        fetch(1, 32'hE000_0001, 30'h711); tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", overflow); end
        fetch(1, 32'hE000_0002, 30'h712); tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        hold = 0;
        fetch(0, 32'h0, '0);
        tick();
        checks++; if (issue_inst !== 32'hE000_0000) begin errors++; $display("FAIL ovf_e0 got %h exp e0000000", issue_inst); end
        tick();
        checks++; if (issue_inst !== 32'hE000_0001) begin errors++; $display("FAIL ovf_e1 got %h exp e0000001", issue_inst); end
        tick();
        checks++; if (issue_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop got v=%b ovf=%b exp 0/1", issue_valid, overflow); end
        do_reset();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_multicycle_hold();
        test_stall_hold();
        test_flush();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
